// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared constants for the multicycle MIPS controller.
// Holds the 4-bit FSM state encodings, the opcodes the controller decodes,
// and the encodings of the datapath mux selects it drives.
package mcycle_pkg;

  // FSM state encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPEEX  = 4'd6;
  localparam logic [3:0] S_RTYPEWB  = 4'd7;
  localparam logic [3:0] S_BRANCHEX = 4'd8;
  localparam logic [3:0] S_JEX      = 4'd9;
  localparam logic [3:0] S_JALEX    = 4'd10;
  localparam logic [3:0] S_IMMEX    = 4'd11;
  localparam logic [3:0] S_IMMWB    = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  // ALU operation select
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mcycle_controller_fetch_beat_ctr.sv
// fetch_beat_ctr: counts instruction-fetch byte beats.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance one beat),
//        beat (current beat index), last (beat is the final one),
//        beat_onehot (one-hot decode of beat, used as IR byte-lane enable).
module fetch_beat_ctr #(
  parameter int FETCH_BEATS = 4,
  parameter int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  output logic [BEAT_W-1:0]      beat,
  output logic                   last,
  output logic [FETCH_BEATS-1:0] beat_onehot
);

  logic [BEAT_W-1:0] beat_r;

  // Beat counter: wraps to zero after the last beat so the next fetch starts at lane 0
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (clr) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (en) begin
      if (last) begin
        beat_r <= {BEAT_W{1'b0}};
      end else begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end else begin
      beat_r <= beat_r;
    end
  end

  assign beat = beat_r;
  assign last = (beat_r == BEAT_W'(FETCH_BEATS - 1));

  for (genvar i = 0; i < FETCH_BEATS; i++) begin : g_onehot
    assign beat_onehot[i] = (beat_r == BEAT_W'(i));
  end

endmodule

// File: rtl/mcycle_controller.sv
// mcycle_controller: multicycle MIPS control FSM with byte-serial fetch and a
// memory-ready handshake on every memory access.
// Ports: clk, rst (sync, active-high); op (IR opcode), zero (ALU zero flag),
//        memready (memory completes this cycle); memread/memwrite strobes,
//        iord, alusrca, alusrcb, aluop, pcsource, regwrite, regdst, memtoreg,
//        irwrite (one-hot IR byte lane), pcen, illegal (opcode trap pulse),
//        state_o (current state, debug).
// All outputs are combinational from state, beat, op, zero and memready.
module mcycle_controller
  import mcycle_pkg::*;
#(
  parameter int FETCH_BEATS = 4,
  parameter int BEAT_W      = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             op,
  input  logic                   zero,
  input  logic                   memready,
  output logic                   memread,
  output logic                   memwrite,
  output logic                   iord,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [2:0]             aluop,
  output logic [1:0]             pcsource,
  output logic                   regwrite,
  output logic [1:0]             regdst,
  output logic [1:0]             memtoreg,
  output logic [FETCH_BEATS-1:0] irwrite,
  output logic                   pcen,
  output logic                   illegal,
  output logic [3:0]             state_o
);

  logic [3:0]             state_r;
  logic [3:0]             next_state_s;
  logic                   in_fetch_s;
  logic                   last_beat_s;
  logic [BEAT_W-1:0]      beat_s;
  logic [FETCH_BEATS-1:0] beat_onehot_s;
  logic                   pcwrite_s;
  logic                   branch_s;
  logic                   branch_taken_s;

  assign in_fetch_s = (state_r == S_FETCH);

  // Held at zero outside FETCH so every fetch begins on lane 0 regardless of history
  fetch_beat_ctr #(
    .FETCH_BEATS (FETCH_BEATS),
    .BEAT_W      (BEAT_W)
  ) u_beat_ctr (
    .clk         (clk),
    .rst         (rst),
    .clr         (~in_fetch_s),
    .en          (memready & in_fetch_s),
    .beat        (beat_s),
    .last        (last_beat_s),
    .beat_onehot (beat_onehot_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state_s = state_r;
    memread      = 1'b0;
    memwrite     = 1'b0;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_B;
    aluop        = ALUOP_ADD;
    pcsource     = PCSRC_ALU;
    regwrite     = 1'b0;
    regdst       = REGDST_RT;
    memtoreg     = M2R_ALUOUT;
    irwrite      = {FETCH_BEATS{1'b0}};
    illegal      = 1'b0;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;

    case (state_r)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_ONE;
        aluop   = ALUOP_ADD;
        // PC+1 and the IR lane are only committed on the beat memory delivers
        if (memready) begin
          irwrite   = beat_onehot_s;
          pcwrite_s = 1'b1;
          if (last_beat_s) begin
            next_state_s = S_DECODE;
          end else begin
            next_state_s = S_FETCH;
          end
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding
        alusrcb = SRCB_IMMSH;
        aluop   = ALUOP_ADD;
        case (op)
          OP_LB, OP_SB:              next_state_s = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI:  next_state_s = S_IMMEX;
          OP_RTYPE:                  next_state_s = S_RTYPEEX;
          OP_BEQ, OP_BNE:            next_state_s = S_BRANCHEX;
          OP_J:                      next_state_s = S_JEX;
          OP_JAL:                    next_state_s = S_JALEX;
          default: begin
            illegal      = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
        if (op == OP_LB) begin
          next_state_s = S_MEMRD;
        end else if (op == OP_SB) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (memready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        regwrite     = 1'b1;
        memtoreg     = M2R_MDR;
        regdst       = REGDST_RT;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (memready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op)
          OP_ANDI: aluop = ALUOP_AND;
          OP_ORI:  aluop = ALUOP_OR;
          default: aluop = ALUOP_ADD;
        endcase
        next_state_s = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite     = 1'b1;
        regdst       = REGDST_RT;
        memtoreg     = M2R_ALUOUT;
        next_state_s = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_B;
        aluop        = ALUOP_FUNCT;
        next_state_s = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite     = 1'b1;
        regdst       = REGDST_RD;
        next_state_s = S_FETCH;
      end
      S_BRANCHEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_B;
        aluop        = ALUOP_SUB;
        pcsource     = PCSRC_ALUOUT;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JEX: begin
        pcwrite_s    = 1'b1;
        pcsource     = PCSRC_JUMP;
        next_state_s = S_FETCH;
      end
      S_JALEX: begin
        // r31 captures the pre-jump PC on the same edge the PC loads the target
        regwrite     = 1'b1;
        regdst       = REGDST_R31;
        memtoreg     = M2R_PC;
        pcwrite_s    = 1'b1;
        pcsource     = PCSRC_JUMP;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase

    // BNE takes the branch on a non-zero compare, BEQ on zero
    if (op == OP_BNE) begin
      branch_taken_s = ~zero;
    end else begin
      branch_taken_s = zero;
    end
    pcen = pcwrite_s | (branch_s & branch_taken_s);
  end

  assign state_o = state_r;

endmodule
